// File: rtl/siu_l2_trk_pkg.sv
// SIU-to-L2 request tracker: shared types and header layout.
// Field positions, WRI encoding, FSM states and the record bundle.
package siu_l2_trk_pkg;

    localparam int OPES_HI = 30;
    localparam int OPES_LO = 27;
    localparam int CFG_HI  = 26;
    localparam int CFG_LO  = 24;
    localparam int TAG_HI  = 21;
    localparam int TAG_LO  = 8;
    localparam int AHI_HI  = 7;
    localparam int AHI_LO  = 0;

    // opes value of a write-invalidate (consumes a WIB credit)
    localparam logic [3:0] OPES_WRI = 4'b0010;

    // chan field is sized for the largest supported bank count
    localparam int CHAN_MAX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_SKIP = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic [CHAN_MAX_W-1:0] chan;
        logic [3:0]            opes;
        logic [2:0]            cfg;
        logic [13:0]           tag;
        logic [39:0]           addr;
    } trk_rec_t;

endpackage

// File: rtl/siu_l2_trk_chan.sv
// One L2 bank: header decode FSM, credit counters,
// single-entry record holding register and sticky errors.
module siu_l2_trk_chan
    import siu_l2_trk_pkg::*;
#(
    parameter int REQ_W        = 32,
    parameter int DUMMY_CYCLES = 3,
    parameter int CNT_W        = 4,
    parameter int CH_IDX       = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_vld_i,
    input  logic [REQ_W-1:0] req_i,
    input  logic             iq_deq_i,
    input  logic             wib_deq_i,
    input  logic             pop_i,
    input  logic             err_clr_i,
    output logic             full_o,
    output trk_rec_t         rec_o,
    output logic [CNT_W-1:0] iq_cnt_o,
    output logic [CNT_W-1:0] wib_cnt_o,
    output logic             proto_err_o,
    output logic             undf_err_o,
    output logic             ovf_err_o,
    output logic             drop_err_o
);

    trk_state_e       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [3:0]       opes_q, opes_d;
    logic [2:0]       cfg_q, cfg_d;
    logic [13:0]      tag_q, tag_d;
    logic [7:0]       ahi_q, ahi_d;
    logic             full_q, full_d;
    trk_rec_t         rec_q, rec_d;
    logic [CNT_W-1:0] iq_q, iq_d;
    logic [CNT_W-1:0] wib_q, wib_d;
    logic             pe_q, pe_d;
    logic             ue_q, ue_d;
    logic             oe_q, oe_d;
    logic             de_q, de_d;

    logic             inc;
    logic             wri;
    logic             pe_ev;
    logic             de_ev;
    trk_rec_t         nrec;
    logic [CNT_W+1:0] iq_res;
    logic [CNT_W+1:0] wib_res;
    logic             unused_req;

    assign unused_req = ^req_i;

    // {underflow, overflow, next count}; inc and deq together cancel
    function automatic logic [CNT_W+1:0] cnt_step(
        input logic [CNT_W-1:0] c,
        input logic             up,
        input logic             dn
    );
        logic [CNT_W-1:0] n;
        logic             u;
        logic             o;
        n = c;
        u = 1'b0;
        o = 1'b0;
        if (up && !dn) begin
            if (&c) o = 1'b1;
            else    n = c + CNT_W'(1);
        end else if (dn && !up) begin
            if (c == '0) u = 1'b1;
            else         n = c - CNT_W'(1);
        end
        return {u, o, n};
    endfunction

    // state register for FSM, holding register, counters and flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            opes_q  <= '0;
            cfg_q   <= '0;
            tag_q   <= '0;
            ahi_q   <= '0;
            full_q  <= 1'b0;
            rec_q   <= '0;
            iq_q    <= '0;
            wib_q   <= '0;
            pe_q    <= 1'b0;
            ue_q    <= 1'b0;
            oe_q    <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            opes_q  <= opes_d;
            cfg_q   <= cfg_d;
            tag_q   <= tag_d;
            ahi_q   <= ahi_d;
            full_q  <= full_d;
            rec_q   <= rec_d;
            iq_q    <= iq_d;
            wib_q   <= wib_d;
            pe_q    <= pe_d;
            ue_q    <= ue_d;
            oe_q    <= oe_d;
            de_q    <= de_d;
        end
    end

    // header decode, record capture and next-state for everything
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        opes_d  = opes_q;
        cfg_d   = cfg_q;
        tag_d   = tag_q;
        ahi_d   = ahi_q;
        full_d  = full_q;
        rec_d   = rec_q;
        inc     = 1'b0;
        wri     = 1'b0;
        pe_ev   = 1'b0;
        de_ev   = 1'b0;

        nrec.chan = CHAN_MAX_W'(CH_IDX);
        nrec.opes = opes_q;
        nrec.cfg  = cfg_q;
        nrec.tag  = tag_q;
        nrec.addr = {ahi_q, req_i[31:0]};

        if (pop_i) full_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_vld_i) begin
                    opes_d  = req_i[OPES_HI:OPES_LO];
                    cfg_d   = req_i[CFG_HI:CFG_LO];
                    tag_d   = req_i[TAG_HI:TAG_LO];
                    ahi_d   = req_i[AHI_HI:AHI_LO];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                pe_ev = req_vld_i;
                inc   = 1'b1;
                wri   = (opes_q == OPES_WRI);
                // a pop on this edge frees the slot for the new record
                if (!full_q || pop_i) begin
                    rec_d  = nrec;
                    full_d = 1'b1;
                end else begin
                    de_ev = 1'b1;
                end
                if (DUMMY_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    skip_d  = 3'(DUMMY_CYCLES);
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                pe_ev  = req_vld_i;
                skip_d = skip_q - 3'd1;
                if (skip_q <= 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        iq_res  = cnt_step(iq_q, inc, iq_deq_i);
        wib_res = cnt_step(wib_q, inc && wri, wib_deq_i);
        iq_d    = iq_res[CNT_W-1:0];
        wib_d   = wib_res[CNT_W-1:0];

        // a same-edge event beats err_clr
        pe_d = (pe_q & ~err_clr_i) | pe_ev;
        ue_d = (ue_q & ~err_clr_i) | iq_res[CNT_W+1] | wib_res[CNT_W+1];
        oe_d = (oe_q & ~err_clr_i) | iq_res[CNT_W] | wib_res[CNT_W];
        de_d = (de_q & ~err_clr_i) | de_ev;
    end

    assign full_o      = full_q;
    assign rec_o       = rec_q;
    assign iq_cnt_o    = iq_q;
    assign wib_cnt_o   = wib_q;
    assign proto_err_o = pe_q;
    assign undf_err_o  = ue_q;
    assign ovf_err_o   = oe_q;
    assign drop_err_o  = de_q;

endmodule

// File: rtl/siu_l2_req_tracker.sv
// SIU-to-L2 request tracker top: per-bank trackers feeding a
// round-robin arbitrated valid/ready record stream.
module siu_l2_req_tracker
    import siu_l2_trk_pkg::*;
#(
    parameter int NUM_L2T      = 8,
    parameter int REQ_W        = 32,
    parameter int DUMMY_CYCLES = 3,
    parameter int CNT_W        = 4,
    parameter int CH_W         = $clog2(NUM_L2T)
) (
    input  logic                       iol2clk,
    input  logic                       rst,
    input  logic [NUM_L2T-1:0]         req_vld,
    input  logic [NUM_L2T*REQ_W-1:0]   req,
    input  logic [NUM_L2T-1:0]         iq_dequeue,
    input  logic [NUM_L2T-1:0]         wib_dequeue,
    input  logic                       rec_rdy,
    output logic                       rec_vld,
    output logic [CH_W-1:0]            rec_chan,
    output logic [3:0]                 rec_opes,
    output logic [2:0]                 rec_config,
    output logic [13:0]                rec_tag,
    output logic [39:0]                rec_addr,
    output logic [NUM_L2T*CNT_W-1:0]   iq_outst,
    output logic [NUM_L2T*CNT_W-1:0]   wib_outst,
    input  logic                       err_clr,
    output logic [NUM_L2T-1:0]         proto_err,
    output logic [NUM_L2T-1:0]         undf_err,
    output logic [NUM_L2T-1:0]         ovf_err,
    output logic [NUM_L2T-1:0]         drop_err
);

    logic [NUM_L2T-1:0] full;
    logic [NUM_L2T-1:0] pop;
    trk_rec_t           recs [NUM_L2T];
    trk_rec_t           sel;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               lock_q, lock_d;
    logic [CH_W-1:0]    lock_gnt_q, lock_gnt_d;
    logic [CH_W-1:0]    rr_gnt;
    logic [CH_W-1:0]    grant;
    logic               unused_chan;

    for (genvar i = 0; i < NUM_L2T; i++) begin : g_chan
        siu_l2_trk_chan #(
            .REQ_W       (REQ_W),
            .DUMMY_CYCLES(DUMMY_CYCLES),
            .CNT_W       (CNT_W),
            .CH_IDX      (i)
        ) u_chan (
            .clk_i      (iol2clk),
            .rst_i      (rst),
            .req_vld_i  (req_vld[i]),
            .req_i      (req[i*REQ_W +: REQ_W]),
            .iq_deq_i   (iq_dequeue[i]),
            .wib_deq_i  (wib_dequeue[i]),
            .pop_i      (pop[i]),
            .err_clr_i  (err_clr),
            .full_o     (full[i]),
            .rec_o      (recs[i]),
            .iq_cnt_o   (iq_outst[i*CNT_W +: CNT_W]),
            .wib_cnt_o  (wib_outst[i*CNT_W +: CNT_W]),
            .proto_err_o(proto_err[i]),
            .undf_err_o (undf_err[i]),
            .ovf_err_o  (ovf_err[i]),
            .drop_err_o (drop_err[i])
        );
    end

    function automatic logic [CH_W-1:0] wrap_add(
        input logic [CH_W-1:0] a,
        input int              k
    );
        int s;
        s = int'(a) + k;
        if (s >= NUM_L2T) s = s - NUM_L2T;
        return CH_W'(s);
    endfunction

    // arbiter pointer and stall lock
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

    // first full bank at or after rr_q; farthest first so nearest wins
    always_comb begin
        rr_gnt = '0;
        for (int k = NUM_L2T - 1; k >= 0; k--) begin
            if (full[wrap_add(rr_q, k)]) rr_gnt = wrap_add(rr_q, k);
        end
    end

    // a stalled grant is frozen so a late-filling bank cannot steal it
    always_comb begin
        grant      = lock_q ? lock_gnt_q : rr_gnt;
        rec_vld    = |full;
        pop        = '0;
        rr_d       = rr_q;
        lock_d     = rec_vld & ~rec_rdy;
        lock_gnt_d = grant;
        if (rec_vld && rec_rdy) begin
            pop[grant] = 1'b1;
            rr_d       = wrap_add(grant, 1);
        end
    end

    assign sel         = recs[grant];
    assign unused_chan = ^sel.chan;

    assign rec_chan   = rec_vld ? sel.chan[CH_W-1:0] : '0;
    assign rec_opes   = rec_vld ? sel.opes : '0;
    assign rec_config = rec_vld ? sel.cfg  : '0;
    assign rec_tag    = rec_vld ? sel.tag  : '0;
    assign rec_addr   = rec_vld ? sel.addr : '0;

endmodule

// File: tb/tb_siu_l2_req_tracker.sv
// Self-checking bench for siu_l2_req_tracker: table vectors,
// directed corner sequences and random traffic vs a packet-level model.
module tb_siu_l2_req_tracker;
    import siu_l2_trk_pkg::*;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int D    = 3;
    localparam int CW   = 4;
    localparam int CHW  = 3;
    localparam int MAXC = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      rv;
    logic [N*W-1:0]    rq;
    logic [N-1:0]      iqd;
    logic [N-1:0]      wbd;
    logic              rdy;
    logic              clr;
    logic              rec_vld;
    logic [CHW-1:0]    rec_chan;
    logic [3:0]        rec_opes;
    logic [2:0]        rec_config;
    logic [13:0]       rec_tag;
    logic [39:0]       rec_addr;
    logic [N*CW-1:0]   iq_outst;
    logic [N*CW-1:0]   wib_outst;
    logic [N-1:0]      proto_err;
    logic [N-1:0]      undf_err;
    logic [N-1:0]      ovf_err;
    logic [N-1:0]      drop_err;

    always #5 clk = ~clk;

    siu_l2_req_tracker #(
        .NUM_L2T(N), .REQ_W(W), .DUMMY_CYCLES(D), .CNT_W(CW)
    ) dut (
        .iol2clk    (clk),
        .rst        (rst),
        .req_vld    (rv),
        .req        (rq),
        .iq_dequeue (iqd),
        .wib_dequeue(wbd),
        .rec_rdy    (rdy),
        .rec_vld    (rec_vld),
        .rec_chan   (rec_chan),
        .rec_opes   (rec_opes),
        .rec_config (rec_config),
        .rec_tag    (rec_tag),
        .rec_addr   (rec_addr),
        .iq_outst   (iq_outst),
        .wib_outst  (wib_outst),
        .err_clr    (clr),
        .proto_err  (proto_err),
        .undf_err   (undf_err),
        .ovf_err    (ovf_err),
        .drop_err   (drop_err)
    );

    int total = 0;
    int bad   = 0;
    int dut_seen [N];

    // packet-level reference model
    int          m_t;
    int          m_hdr_t [N];
    int          m_busy  [N];
    logic [31:0] m_hdr   [N];
    bit          m_full  [N];
    logic [3:0]  m_opes  [N];
    logic [2:0]  m_cfg   [N];
    logic [13:0] m_tag   [N];
    logic [39:0] m_addr  [N];
    int          m_iq    [N];
    int          m_wib   [N];
    bit          m_pe [N], m_ue [N], m_oe [N], m_de [N];
    int          m_rr;
    int          m_lock;

    typedef struct {
        logic        rv0;
        logic [31:0] w;
        logic        dq;
        logic        e_vld;
        logic [2:0]  e_chan;
        logic [3:0]  e_opes;
        logic [2:0]  e_cfg;
        logic [13:0] e_tag;
        logic [39:0] e_addr;
        logic [3:0]  e_iq;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hdr_t[i] = -10;
            m_busy[i]  = 0;
            m_hdr[i]   = '0;
            m_full[i]  = 0;
            m_opes[i]  = '0;
            m_cfg[i]   = '0;
            m_tag[i]   = '0;
            m_addr[i]  = '0;
            m_iq[i]    = 0;
            m_wib[i]   = 0;
            m_pe[i]    = 0;
            m_ue[i]    = 0;
            m_oe[i]    = 0;
            m_de[i]    = 0;
        end
        m_rr   = 0;
        m_lock = -1;
    endtask

    function automatic int m_grant();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++)
            if (m_full[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic int cstep(input int c, input int net,
                                 output bit u, output bit o);
        u = 0;
        o = 0;
        if (net > 0) begin
            if (c == MAXC) o = 1;
            else           return c + 1;
        end else if (net < 0) begin
            if (c == 0) u = 1;
            else        return c - 1;
        end
        return c;
    endfunction

    task automatic model_edge();
        int g, popped, inc, wri;
        bit pe, de, u1, o1, u2, o2;
        logic [31:0] w;
        g = m_grant();
        popped = (g >= 0 && rdy) ? g : -1;
        for (int i = 0; i < N; i++) begin
            w = rq[i*W +: W];
            inc = 0; wri = 0; pe = 0; de = 0;
            if (m_hdr_t[i] == m_t - 1) begin
                inc = 1;
                wri = (m_hdr[i][30:27] == OPES_WRI) ? 1 : 0;
                if (!m_full[i] || popped == i) begin
                    m_full[i] = 1;
                    m_opes[i] = m_hdr[i][30:27];
                    m_cfg[i]  = m_hdr[i][26:24];
                    m_tag[i]  = m_hdr[i][21:8];
                    m_addr[i] = {m_hdr[i][7:0], w};
                end else begin
                    de = 1;
                end
            end else if (popped == i) begin
                m_full[i] = 0;
            end
            if (rv[i]) begin
                if (m_t >= m_busy[i]) begin
                    m_hdr_t[i] = m_t;
                    m_busy[i]  = m_t + 2 + D;
                    m_hdr[i]   = w;
                end else begin
                    pe = 1;
                end
            end
            m_iq[i]  = cstep(m_iq[i], inc - int'(iqd[i]), u1, o1);
            m_wib[i] = cstep(m_wib[i], wri - int'(wbd[i]), u2, o2);
            m_pe[i] = (m_pe[i] && !clr) || pe;
            m_ue[i] = (m_ue[i] && !clr) || u1 || u2;
            m_oe[i] = (m_oe[i] && !clr) || o1 || o2;
            m_de[i] = (m_de[i] && !clr) || de;
        end
        if (popped >= 0) m_rr = (popped + 1) % N;
        m_lock = (g >= 0 && !rdy) ? g : -1;
        m_t++;
    endtask

    task automatic check_all();
        int g;
        logic [N-1:0] pe, ue, oe, de;
        g = m_grant();
        chk("rec_vld", 64'(rec_vld), 64'(g >= 0));
        if (g >= 0) begin
            chk("rec_chan", 64'(rec_chan), 64'(g));
            chk("rec_opes", 64'(rec_opes), 64'(m_opes[g]));
            chk("rec_config", 64'(rec_config), 64'(m_cfg[g]));
            chk("rec_tag", 64'(rec_tag), 64'(m_tag[g]));
            chk("rec_addr", 64'(rec_addr), 64'(m_addr[g]));
        end else begin
            chk("rec_idle", 64'({rec_chan, rec_opes, rec_config, rec_tag}), 64'(0));
            chk("rec_addr_idle", 64'(rec_addr), 64'(0));
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("iq_outst[%0d]", i), 64'(iq_outst[i*CW +: CW]), 64'(m_iq[i]));
            chk($sformatf("wib_outst[%0d]", i), 64'(wib_outst[i*CW +: CW]), 64'(m_wib[i]));
            pe[i] = m_pe[i];
            ue[i] = m_ue[i];
            oe[i] = m_oe[i];
            de[i] = m_de[i];
        end
        chk("proto_err", 64'(proto_err), 64'(pe));
        chk("undf_err", 64'(undf_err), 64'(ue));
        chk("ovf_err", 64'(ovf_err), 64'(oe));
        chk("drop_err", 64'(drop_err), 64'(de));
    endtask

    // one clock: model and DUT both take the edge, then compare
    task automatic step();
        if (rec_vld && rdy) dut_seen[rec_chan]++;
        model_edge();
        @(negedge clk);
        check_all();
        rv  = '0;
        iqd = '0;
        wbd = '0;
        clr = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    task automatic set_w(input int b, input logic [31:0] w);
        rq[b*W +: W] = w;
    endtask

    initial begin
        int s3;
        logic [39:0] first_addr;

        tbl[0] = '{1'b1, 32'h2A12345F, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 14'h0,    40'h0,          4'd0};
        tbl[1] = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 3'd0, 4'd5, 3'd2, 14'h1234, 40'h5FDEADBEEF, 4'd1};
        tbl[2] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 14'h0,    40'h0,          4'd0};
        tbl[3] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 14'h0,    40'h0,          4'd0};

        for (int i = 0; i < N; i++) dut_seen[i] = 0;
        m_t = 0;
        rst = 1'b1;
        rv  = '0;
        rq  = '0;
        iqd = '0;
        wbd = '0;
        rdy = 1'b1;
        clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all();
        chk("reset rec_vld", 64'(rec_vld), 64'(0));
        chk("reset iq_outst", 64'(iq_outst), 64'(0));
        chk("reset errs", 64'({proto_err, undf_err, ovf_err, drop_err}), 64'(0));

        // bank 0 basic record, latency and dequeue
        for (int r = 0; r < 4; r++) begin
            rv[0]  = tbl[r].rv0;
            set_w(0, tbl[r].w);
            iqd[0] = tbl[r].dq;
            step();
            chk($sformatf("tbl%0d vld", r), 64'(rec_vld), 64'(tbl[r].e_vld));
            chk($sformatf("tbl%0d chan", r), 64'(rec_chan), 64'(tbl[r].e_chan));
            chk($sformatf("tbl%0d opes", r), 64'(rec_opes), 64'(tbl[r].e_opes));
            chk($sformatf("tbl%0d cfg", r), 64'(rec_config), 64'(tbl[r].e_cfg));
            chk($sformatf("tbl%0d tag", r), 64'(rec_tag), 64'(tbl[r].e_tag));
            chk($sformatf("tbl%0d addr", r), 64'(rec_addr), 64'(tbl[r].e_addr));
            chk($sformatf("tbl%0d iq0", r), 64'(iq_outst[3:0]), 64'(tbl[r].e_iq));
        end

        // bank 3: req_vld during SKIP is a protocol error
        s3 = dut_seen[3];
        rv[3] = 1'b1; set_w(3, 32'h00000033); step();
        set_w(3, 32'h33333333); step();
        rv[3] = 1'b1; step();
        chk("proto_err[3] set", 64'(proto_err[3]), 64'(1));
        clr = 1'b1; step();
        step();
        chk("bank3 one record", 64'(dut_seen[3] - s3), 64'(1));
        rv[3] = 1'b1; set_w(3, 32'h00000044); step();
        step();
        step();
        chk("proto_err[3] after T+5", 64'(proto_err[3]), 64'(0));
        chk("iq_outst[3]", 64'(iq_outst[15:12]), 64'(2));
        chk("bank3 two records", 64'(dut_seen[3] - s3), 64'(2));

        // banks 1, 4, 7 together, then 7 and 1 for wrap
        do_reset();
        rv = 8'b1001_0010; step();
        step();
        chk("rr first", 64'(rec_chan), 64'(1)); step();
        chk("rr second", 64'(rec_chan), 64'(4)); step();
        chk("rr third", 64'(rec_chan), 64'(7)); step();
        chk("rr drained", 64'(rec_vld), 64'(0));
        rv = 8'b1000_0010; step();
        step();
        chk("wrap first", 64'(rec_chan), 64'(1)); step();
        chk("wrap second", 64'(rec_chan), 64'(7)); step();

        // bank 2 stalled: second record dropped
        rdy = 1'b0;
        rv[2] = 1'b1; set_w(2, 32'h0B00AA11); step();
        set_w(2, 32'h01234567); step();
        first_addr = rec_addr;
        chk("hold addr", 64'(rec_addr), 64'h1101234567);
        chk("hold opes", 64'(rec_opes), 64'(1));
        steps(3);
        rv[2] = 1'b1; set_w(2, 32'h7FFFFFFF); step();
        set_w(2, 32'h89ABCDEF); step();
        chk("hold stable", 64'(rec_addr), 64'(first_addr));
        chk("drop_err[2]", 64'(drop_err[2]), 64'(1));
        chk("iq_outst[2]", 64'(iq_outst[11:8]), 64'(2));
        rdy = 1'b1; step();
        chk("after drop drained", 64'(rec_vld), 64'(0));
        steps(3);

        // bank 5 underflow then saturation
        iqd[5] = 1'b1; step();
        chk("iq_outst[5] undf", 64'(iq_outst[23:20]), 64'(0));
        chk("undf_err[5]", 64'(undf_err[5]), 64'(1));
        for (int p = 0; p < 16; p++) begin
            rv[5] = 1'b1; set_w(5, 32'h00000055); step();
            set_w(5, p); steps(4);
        end
        chk("iq_outst[5] sat", 64'(iq_outst[23:20]), 64'(15));
        chk("ovf_err[5]", 64'(ovf_err[5]), 64'(1));
        clr = 1'b1; step();
        chk("err_clr", 64'({proto_err, undf_err, ovf_err, drop_err}), 64'(0));

        // reset while bank 6 is in ADDR
        rv[6] = 1'b1; set_w(6, 32'h00000066); step();
        do_reset();
        steps(3);
        chk("abort no rec", 64'(rec_vld), 64'(0));
        chk("abort iq", 64'(iq_outst), 64'(0));
        rv[6] = 1'b1; set_w(6, 32'h000000A6); step();
        set_w(6, 32'h12345678); step();
        chk("post-reset chan", 64'(rec_chan), 64'(6));
        chk("post-reset addr", 64'(rec_addr), 64'hA612345678);
        chk("post-reset iq6", 64'(iq_outst[27:24]), 64'(1));
        step();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                rv[i]  = ($urandom_range(0, 4) == 0);
                iqd[i] = ($urandom_range(0, 5) == 0);
                wbd[i] = ($urandom_range(0, 5) == 0);
                rq[i*W +: W] = $urandom;
            end
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/siu_l2_req_tracker.md
Name: siu_l2_req_tracker

Overview:
- Parametrised, synthesizable SIU-to-L2 inbound request tracker for NUM_L2T L2 tag banks.
- Taps the SII request bus per bank (req_vld, 32-bit req word, iq_dequeue, wib_dequeue) alongside the live interface.
- Decodes the two-cycle header, skips the dummy cycles, and keeps per-bank outstanding IQ and WIB credit counts.
- Reports completed headers through one round-robin arbitrated record stream with valid/ready. Sticky protocol-error flags cover violations.

Parameters:
- NUM_L2T, 8, number of L2 tag banks (channels); must be ≥2.
- REQ_W, 32, width of the sii_l2tN_req word.
- DUMMY_CYCLES, 3, cycles skipped after the address word; range 0..7.
- CNT_W, 4, width of each outstanding counter; saturates at 2^CNT_W-1.
- CH_W, $clog2(NUM_L2T), width of the channel index.

Ports:
- iol2clk  in  1  I/O-L2 clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  NUM_L2T  per-bank sii_l2t_req_vld.
- req  in  NUM_L2T*REQ_W  per-bank request words, bank i at [i*REQ_W +: REQ_W].
- iq_dequeue  in  NUM_L2T  per-bank l2t_sii_iq_dequeue.
- wib_dequeue  in  NUM_L2T  per-bank l2t_sii_wib_dequeue.
- rec_rdy  in  1  downstream accepts the record.
- rec_vld  out  1  record valid.
- rec_chan  out  CH_W  bank index of the record.
- rec_opes  out  4  header word bits [30:27].
- rec_config  out  3  header word bits [26:24].
- rec_tag  out  14  header word bits [21:8].
- rec_addr  out  40  {header[7:0], address word[31:0]}.
- iq_outst  out  NUM_L2T*CNT_W  per-bank outstanding IQ count.
- wib_outst  out  NUM_L2T*CNT_W  per-bank outstanding WIB (WRI) count.
- err_clr  in  1  clears all sticky error vectors.
- proto_err  out  NUM_L2T  sticky: req_vld seen while the bank is not IDLE.
- undf_err  out  NUM_L2T  sticky: dequeue seen with count 0.
- ovf_err  out  NUM_L2T  sticky: increment seen at saturation.
- drop_err  out  NUM_L2T  sticky: record lost because the holding register was full.

Behaviour:
- Reset: every FSM goes to IDLE, all counters, holding registers, error vectors and the round-robin pointer go to 0. rec_vld=0 and all rec_* outputs are 0.
- Per-bank FSM, states IDLE, ADDR, SKIP:
  - IDLE: on an edge with req_vld[i]=1, latch opes, config, tag and addr[39:32] from req; go to ADDR.
  - ADDR: on the next edge, latch addr[31:0]. Write the full record to the bank's holding register. Increment iq_outst, and also wib_outst when opes marks a WRI. Load the skip counter with DUMMY_CYCLES and go to SKIP; if DUMMY_CYCLES=0, go to IDLE.
  - SKIP: decrement the skip counter each edge; go to IDLE on the edge where it reaches 0.
  - req_vld sampled in ADDR or SKIP sets proto_err[i]. The request is ignored and the FSM is not disturbed.
  - With DUMMY_CYCLES=3, back-to-back packets are legal every 5 cycles.
- Record latency: header edge T → holding register full after edge T+1 → rec_vld can assert in cycle T+2.
- Counters, each edge:
  - increment and dequeue on the same edge: count unchanged, no flags.
  - dequeue at 0: hold 0, set undf_err.
  - increment at max: hold max, set ovf_err.
- Holding register, one per bank:
  - When the arbiter pops a register on the same edge it refills, the new record is stored and there is no drop.
  - A refill while full and not popped keeps the old record, discards the new one, and sets drop_err. The counters still increment.
- Output arbiter:
  - rec_vld = OR of holding-full flags; rec_* are a combinational mux of the granted bank.
  - Grant goes to the first full bank at or after rr_ptr, with wrap-around.
  - On rec_vld && rec_rdy: pop that bank and set rr_ptr = grant+1 mod NUM_L2T.
  - While rec_vld && !rec_rdy, the grant and rec_* stay stable.
- err_clr clears all sticky vectors. An error event on the same edge wins, so its flag stays 1.
- Reset asserted mid-packet aborts the packet without emitting a record.

Decomposition:
- Package siu_l2_trk_pkg holds:
  - header field bit positions (OPES 30:27, CONFIG 26:24, TAG 21:8, ADDR_HI 7:0);
  - the WRI opes encoding;
  - the FSM state enum;
  - the record struct (chan, opes, config, tag, addr).
- One sub-module, siu_l2_trk_chan, is instantiated NUM_L2T times. It contains the FSM, skip counter, two counters, holding register and the four error bits.
- The top level holds the round-robin arbiter and the output mux.

Test Plan:
- Bank 0: req_vld with req=0x2A_1234_5F then req=0xDEADBEEF. Required: rec_vld in cycle T+2 with chan=0, opes=req[30:27], tag=req[21:8], addr=0x5F_DEADBEEF; iq_outst[0]=1. One iq_dequeue[0] → 0.
- Bank 3: second req_vld at T+2 (in SKIP). Required: proto_err[3]=1, one record only. req_vld at T+5 is accepted with no error.
- Banks 1, 4, 7 complete on the same edge with rec_rdy=1. Required: records emitted in order 1, 4, 7 on consecutive cycles. A later single pair on banks 7 and 1 emits 1 then 7 (pointer wrap).
- rec_rdy=0, bank 2 sends two packets 5 cycles apart. Required: first record held stable, drop_err[2]=1, iq_outst[2]=2. Then rec_rdy=1 yields the first record only.
- iq_dequeue[5] at count 0: count stays 0, undf_err[5]=1.
- 16 packets on bank 5 without dequeue (CNT_W=4): count saturates at 15, ovf_err[5]=1. err_clr clears all flags.
- Reset asserted in ADDR on bank 6: no record, counters 0, FSM IDLE. The next packet after reset release is accepted normally.
